// File: rtl/pix_pack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pix_pack_pkg                                           |
// | Purpose : shared widths, FSM encoding and lane helper for the    |
// |           RGB565 -> 64-bit write packer                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pix_pack_pkg;

  localparam int PIX_W      = 16;
  localparam int LANES      = 4;
  localparam int WORD_W     = PIX_W * LANES;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;

  function automatic logic [WORD_W-1:0] lane_insert(
    input logic [WORD_W-1:0]     word,
    input logic [LANE_IDX_W-1:0] lane,
    input logic [PIX_W-1:0]      pix
  );
    logic [WORD_W-1:0] r;
    r = word;
    r[lane*PIX_W +: PIX_W] = pix;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pack_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pack_fifo                                              |
// | Purpose : synchronous first-word-fall-through FIFO with clear    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pack_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_rd   = rd_en_i & ~empty_o;
  // A write into a full FIFO only lands when a read frees the slot in the same cycle.
  assign do_wr   = wr_en_i & (~full_o | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sobel_wr_packer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sobel_wr_packer                                        |
// | Purpose : packs RGB565 pixels four per 64-bit word into a FWFT   |
// |           FIFO feeding a write master. PIX_PACK_FLUSH_EN flushes |
// |           partial words zero-padded at line end.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sobel_wr_packer
  import pix_pack_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  rx_data,
  input  logic              pi_flag,
  input  logic              frame_start,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              wr_last,
  output logic              frame_done,
  output logic              ovf,
  output logic [15:0]       line_cnt
);

  localparam int                    CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]           H_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0]           V_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]      ONE_WORD = CNT_W'(1);
  localparam logic [LANE_IDX_W-1:0] LANE_TOP = LANE_IDX_W'(LANES - 1);
  localparam logic [LANE_IDX_W-1:0] LANE_ONE = LANE_IDX_W'(1);
`ifdef PIX_PACK_FLUSH_EN
  localparam logic FLUSH_EN = 1'b1;
`else
  localparam logic FLUSH_EN = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d, lane_cur;
  logic [15:0]           pix_q, pix_d, pix_cur;
  logic [15:0]           line_q, line_d, line_cur;
  logic [WORD_W-1:0]     word_q, word_d, word_cur, word_ins;
  logic                  push_q, push_d;
  logic [WORD_W-1:0]     push_data_q, push_data_d;
  logic                  push_last_q, push_last_d;
  logic                  ovf_q, ovf_d;
  logic                  accept, line_end;

  logic [WORD_W:0]       fifo_rd;
  logic                  fifo_empty, fifo_full, fifo_pop;
  logic [CNT_W-1:0]      fifo_cnt;

  assign fifo_pop = wr_valid & wr_ready;

  always_comb begin
    state_d     = state_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_last_d = push_last_q;
    ovf_d       = ovf_q | (push_q & fifo_full & ~fifo_pop);
    frame_done  = 1'b0;
    // frame_start restarts everything; a coincident pixel lands as pixel 0.
    lane_cur    = frame_start ? '0 : lane_q;
    pix_cur     = frame_start ? '0 : pix_q;
    line_cur    = frame_start ? '0 : line_q;
    word_cur    = frame_start ? '0 : word_q;
    lane_d      = lane_cur;
    pix_d       = pix_cur;
    line_d      = line_cur;
    word_d      = word_cur;
    word_ins    = lane_insert(word_cur, lane_cur, rx_data);
    line_end    = (pix_cur == H_LAST);
    accept      = pi_flag & (frame_start | (state_q == ST_ACTIVE));

    if (frame_start) begin
      state_d = ST_ACTIVE;
      ovf_d   = 1'b0;
    end

    if (accept) begin
      push_d      = (lane_cur == LANE_TOP) | (FLUSH_EN & line_end);
      push_data_d = word_ins;
      push_last_d = line_end;
      // Lanes above the write position stay zero, which provides the flush padding.
      word_d      = (push_d | line_end) ? '0 : word_ins;
      lane_d      = (push_d | line_end) ? '0 : lane_cur + LANE_ONE;
      pix_d       = line_end ? '0 : pix_cur + 16'd1;
      line_d      = line_end ? line_cur + 16'd1 : line_cur;
      if (line_end && (line_cur == V_LAST)) state_d = ST_DRAIN;
    end

    if (!frame_start && (state_q == ST_DRAIN) && !push_q) begin
      if (fifo_empty) begin
        state_d = ST_IDLE;
      end else if (fifo_pop && (fifo_cnt == ONE_WORD)) begin
        state_d    = ST_IDLE;
        frame_done = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_last_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      word_q      <= word_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      push_last_q <= push_last_d;
      ovf_q       <= ovf_d;
    end
  end

  pack_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (sclk),
    .rst_ni    (rst_n),
    .clr_i     (frame_start),
    .wr_en_i   (push_q),
    .wr_data_i ({push_last_q, push_data_q}),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_cnt)
  );

  assign wr_valid = ~fifo_empty;
  assign wr_data  = fifo_rd[WORD_W-1:0];
  assign wr_last  = fifo_rd[WORD_W];
  assign ovf      = ovf_q;
  assign line_cnt = line_q;

endmodule
`default_nettype wire
